// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the seven-segment scanner.
//                Patterns are active-low, bit 7 = DP (off), bits 6:0 = g..a.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [7:0] seg7_pat_t;

    localparam seg7_pat_t SEG_0 = 8'hC0;
    localparam seg7_pat_t SEG_1 = 8'hF9;
    localparam seg7_pat_t SEG_2 = 8'hA4;
    localparam seg7_pat_t SEG_3 = 8'hB0;
    localparam seg7_pat_t SEG_4 = 8'h99;
    localparam seg7_pat_t SEG_5 = 8'h92;
    localparam seg7_pat_t SEG_6 = 8'h82;
    localparam seg7_pat_t SEG_7 = 8'hD8;
    localparam seg7_pat_t SEG_8 = 8'h80;
    localparam seg7_pat_t SEG_9 = 8'h90;
    localparam seg7_pat_t SEG_A = 8'h88;
    localparam seg7_pat_t SEG_B = 8'h83;
    localparam seg7_pat_t SEG_C = 8'hA7;
    localparam seg7_pat_t SEG_D = 8'hA1;
    localparam seg7_pat_t SEG_E = 8'h86;
    localparam seg7_pat_t SEG_F = 8'h8E;

    // All segments and DP dark
    localparam seg7_pat_t SEG_BLANK = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/seg7_nibble_dec.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_nibble_dec
//  Description : Pure combinational hex nibble to active-low g..a segments.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_nibble_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup into the shared pattern constants (DP bit dropped)
    always_comb begin
        seg = SEG_BLANK[6:0];
        case (nib)
            4'h0: seg = SEG_0[6:0];
            4'h1: seg = SEG_1[6:0];
            4'h2: seg = SEG_2[6:0];
            4'h3: seg = SEG_3[6:0];
            4'h4: seg = SEG_4[6:0];
            4'h5: seg = SEG_5[6:0];
            4'h6: seg = SEG_6[6:0];
            4'h7: seg = SEG_7[6:0];
            4'h8: seg = SEG_8[6:0];
            4'h9: seg = SEG_9[6:0];
            4'hA: seg = SEG_A[6:0];
            4'hB: seg = SEG_B[6:0];
            4'hC: seg = SEG_C[6:0];
            4'hD: seg = SEG_D[6:0];
            4'hE: seg = SEG_E[6:0];
            4'hF: seg = SEG_F[6:0];
            default: seg = SEG_BLANK[6:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Time-multiplexed driver for DIGITS active-low common-anode
//                seven-segment digits. Frame-synchronous shadow register,
//                ghost blanking on every digit change, registered outputs.
//                Optional macro SEG7_LZB_EN compiles in leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [4*DIGITS-1:0]   DIN,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LOAD,
    output logic [7:0]            nHEX,
    output logic [DIGITS-1:0]     nDIG,
    output logic                  FRAME,
    output logic                  PEND
);

    localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
    localparam logic [PCNT_W-1:0] PCNT_TC  = PCNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // State
    logic [PCNT_W-1:0]   pcnt, pcnt_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [4*DIGITS-1:0] pnd_din, pnd_din_nxt, act_din, act_din_nxt;
    logic [DIGITS-1:0]   pnd_dp, pnd_dp_nxt, act_dp, act_dp_nxt;
    logic                pend_q, pend_nxt;
    logic                tc, wrap;

    // Output path
    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic [6:0]          seg_dec, seg_shown;
    logic [7:0]          hex_nxt;
    logic [DIGITS-1:0]   dig_nxt;

    // Prescaler, scan index and shadow-register transfer rules
    always_comb begin
        tc          = (pcnt == PCNT_TC);
        wrap        = tc && (idx == IDX_LAST);
        pcnt_nxt    = tc ? '0 : pcnt + 1'b1;
        idx_nxt     = idx;
        pnd_din_nxt = pnd_din;
        pnd_dp_nxt  = pnd_dp;
        act_din_nxt = act_din;
        act_dp_nxt  = act_dp;
        pend_nxt    = pend_q;
        if (tc) begin
            idx_nxt = wrap ? '0 : idx + 1'b1;
        end
        if (LOAD) begin
            pnd_din_nxt = DIN;
            pnd_dp_nxt  = DP;
        end
        if (wrap) begin
            // A load on the wrap edge bypasses the pending stage entirely
            pend_nxt = 1'b0;
            if (LOAD) begin
                act_din_nxt = DIN;
                act_dp_nxt  = DP;
            end else if (pend_q) begin
                act_din_nxt = pnd_din;
                act_dp_nxt  = pnd_dp;
            end
        end else if (LOAD) begin
            pend_nxt = 1'b1;
        end
    end

    // Select the nibble and DP of the digit that will be on after this edge
    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nib_sel = act_din_nxt[4*i +: 4];
                dp_sel  = act_dp_nxt[i];
            end
        end
    end

    seg7_nibble_dec u_dec (
        .nib (nib_sel),
        .seg (seg_dec)
    );

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              lz_sel;

    // Digit i is a leading zero when it and every digit above it are zero
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_lsd
                assign lz[gi] = 1'b0;
            end else begin : g_upper
                assign lz[gi] = (act_din_nxt[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // Pick the blanking flag of the upcoming digit
    always_comb begin
        lz_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                lz_sel = lz[i];
            end
        end
    end

    assign seg_shown = lz_sel ? 7'h7F : seg_dec;
`else
    assign seg_shown = seg_dec;
`endif

    // Next output values; the first cycle of every digit slot is dark
    always_comb begin
        hex_nxt = SEG_BLANK;
        dig_nxt = '1;
        if (pcnt_nxt != '0) begin
            hex_nxt = {~dp_sel, seg_shown};
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_nxt == IDX_W'(i)) begin
                    dig_nxt[i] = 1'b0;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pcnt    <= '0;
            idx     <= '0;
            pnd_din <= '0;
            pnd_dp  <= '0;
            act_din <= '0;
            act_dp  <= '0;
            pend_q  <= 1'b0;
            nHEX    <= SEG_BLANK;
            nDIG    <= '1;
            FRAME   <= 1'b0;
        end else begin
            pcnt    <= pcnt_nxt;
            idx     <= idx_nxt;
            pnd_din <= pnd_din_nxt;
            pnd_dp  <= pnd_dp_nxt;
            act_din <= act_din_nxt;
            act_dp  <= act_dp_nxt;
            pend_q  <= pend_nxt;
            nHEX    <= hex_nxt;
            nDIG    <= dig_nxt;
            FRAME   <= wrap;
        end
    end

    assign PEND = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan
//  Description : Self-checking bench for seg7_scan (DIGITS=4, SCAN_DIV=4).
//                Expected outputs come from a cycle-count reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan;

    localparam int DIG = 4;
    localparam int SD  = 4;
    localparam int FR  = DIG * SD;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] DIN  = '0;
    logic [3:0]  DP   = '0;
    logic [7:0]  nHEX;
    logic [3:0]  nDIG;
    logic        FRAME;
    logic        PEND;

    seg7_scan #(.DIGITS(DIG), .SCAN_DIV(SD)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .DIN   (DIN),
        .DP    (DP),
        .LOAD  (LOAD),
        .nHEX  (nHEX),
        .nDIG  (nDIG),
        .FRAME (FRAME),
        .PEND  (PEND)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Reference model: edges since reset release, displayed and pending data
    int          m_n;
    logic [15:0] m_val, m_pval;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pend;

    logic [7:0] PAT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

    task automatic model_reset();
        m_n = 0; m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0; m_pend = 1'b0;
    endtask

    // Every FR-th edge is a frame boundary
    task automatic model_edge(input logic ld, input logic [15:0] d, input logic [3:0] p);
        m_n++;
        if (m_n % FR == 0) begin
            if (ld) begin
                m_val = d; m_dp = p;
            end else if (m_pend) begin
                m_val = m_pval; m_dp = m_pdp;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pval = d; m_pdp = p; m_pend = 1'b1;
        end
    endtask

    // Expected {nHEX, nDIG, FRAME, PEND} after edge m_n
    function automatic logic [13:0] exp_vec();
        int         pc, ix;
        logic [3:0] dig, v;
        logic [7:0] hex;
        logic [6:0] s;
        pc  = m_n % SD;
        ix  = (m_n / SD) % DIG;
        dig = 4'hF;
        hex = 8'hFF;
        if (pc != 0) begin
            dig[ix] = 1'b0;
            v   = m_val[4*ix +: 4];
            hex = PAT[v];
            s   = hex[6:0];
`ifdef SEG7_LZB_EN
            if (ix > 0 && (m_val >> (4*ix)) == 16'h0) s = 7'h7F;
`endif
            hex = {~m_dp[ix], s};
        end
        return {hex, dig, (m_n != 0 && m_n % FR == 0), m_pend};
    endfunction

    task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] p);
        LOAD = ld; DIN = d; DP = p;
        @(posedge CLK);
        model_edge(ld, d, p);
        #1;
        LOAD = 1'b0;
    endtask

    task automatic advance_to(input int r);
        while (m_n % FR != r) tick(1'b0, DIN, DP);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({nHEX, nDIG, FRAME, PEND} !== {8'hFF, 4'hF, 1'b0, 1'b0})
            $display("FAIL reset_hold got=%h exp=%h", {nHEX, nDIG, FRAME, PEND}, {8'hFF, 4'hF, 2'b00});
        else passes++;
        model_reset();
        nRST = 1'b1;
        for (int i = 0; i <= 2 * FR + 4; i++) begin
            if (i > 0) tick(1'b0, 16'h0, 4'h0);
            checks++;
            if ({nHEX, nDIG, FRAME, PEND} !== exp_vec())
                $display("FAIL reset_scan n=%0d got=%h exp=%h", m_n, {nHEX, nDIG, FRAME, PEND}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_load_mid();
        advance_to(6);
        tick(1'b1, 16'h12AF, 4'b0100);
        checks++;
        if (PEND !== 1'b1) $display("FAIL load_mid_pend got=%b exp=1", PEND);
        else passes++;
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0, 16'h0, 4'h0);
            checks++;
            if ({nHEX, nDIG, FRAME, PEND} !== exp_vec())
                $display("FAIL load_mid n=%0d got=%h exp=%h", m_n, {nHEX, nDIG, FRAME, PEND}, exp_vec());
            else passes++;
        end
        advance_to(10);
        checks++;
        if (nHEX !== 8'h24) $display("FAIL load_mid_dp_digit got=%h exp=24", nHEX);
        else passes++;
    endtask

    task automatic test_load_on_wrap();
        advance_to(FR - 1);
        tick(1'b1, 16'h0007, 4'h0);
        checks++;
        if ({FRAME, PEND} !== 2'b10) $display("FAIL wrap_load_flags got=%b exp=10", {FRAME, PEND});
        else passes++;
        tick(1'b0, 16'h0, 4'h0);
        checks++;
        if (nHEX !== 8'hD8) $display("FAIL wrap_load_digit0 got=%h exp=d8", nHEX);
        else passes++;
        for (int i = 0; i < FR; i++) begin
            tick(1'b0, 16'h0, 4'h0);
            checks++;
            if ({nHEX, nDIG, FRAME, PEND} !== exp_vec())
                $display("FAIL wrap_load n=%0d got=%h exp=%h", m_n, {nHEX, nDIG, FRAME, PEND}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        advance_to(2);
        tick(1'b1, 16'h1111, 4'h0);
        advance_to(9);
        tick(1'b1, 16'h2222, 4'h0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 16'h0, 4'h0);
            checks++;
            if ({nHEX, nDIG, FRAME, PEND} !== exp_vec())
                $display("FAIL back_to_back n=%0d got=%h exp=%h", m_n, {nHEX, nDIG, FRAME, PEND}, exp_vec());
            else passes++;
        end
        advance_to(5);
        checks++;
        if (nHEX !== 8'hA4) $display("FAIL back_to_back_last got=%h exp=a4", nHEX);
        else passes++;
    endtask

    task automatic test_lzb();
        advance_to(FR - 1);
        tick(1'b1, 16'h0050, 4'b1000);
        for (int i = 0; i < FR; i++) begin
            tick(1'b0, 16'h0, 4'h0);
            checks++;
            if ({nHEX, nDIG, FRAME, PEND} !== exp_vec())
                $display("FAIL lzb n=%0d got=%h exp=%h", m_n, {nHEX, nDIG, FRAME, PEND}, exp_vec());
            else passes++;
        end
        advance_to(13);
        checks++;
`ifdef SEG7_LZB_EN
        if (nHEX !== 8'h7F) $display("FAIL lzb_digit3 got=%h exp=7f", nHEX);
`else
        if (nHEX !== 8'h40) $display("FAIL lzb_digit3 got=%h exp=40", nHEX);
`endif
        else passes++;
    endtask

    task automatic test_random();
        logic        ld;
        logic [15:0] d;
        logic [3:0]  p;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            d  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
            p  = 4'($urandom);
            tick(ld, d, p);
            checks++;
            if ({nHEX, nDIG, FRAME, PEND} !== exp_vec())
                $display("FAIL random n=%0d got=%h exp=%h", m_n, {nHEX, nDIG, FRAME, PEND}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        advance_to(1);
        tick(1'b1, 16'hBEEF, 4'b1010);
        advance_to(10);
        checks++;
        if ({PEND, nDIG} !== {1'b1, 4'b1011})
            $display("FAIL rst_mid_pre got=%b exp=11011", {PEND, nDIG});
        else passes++;
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({nHEX, nDIG, FRAME, PEND} !== {8'hFF, 4'hF, 1'b0, 1'b0})
            $display("FAIL rst_mid_async got=%h exp=%h", {nHEX, nDIG, FRAME, PEND}, {8'hFF, 4'hF, 2'b00});
        else passes++;
        @(posedge CLK);
        #1;
        model_reset();
        nRST = 1'b1;
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0, 16'h0, 4'h0);
            checks++;
            if ({nHEX, nDIG, FRAME, PEND} !== exp_vec())
                $display("FAIL rst_mid_after n=%0d got=%h exp=%h", m_n, {nHEX, nDIG, FRAME, PEND}, exp_vec());
            else passes++;
            if (i == 0) begin
                checks++;
                if (nHEX !== 8'hC0) $display("FAIL rst_mid_c0 got=%h exp=c0", nHEX);
                else passes++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_mid();
        test_load_on_wrap();
        test_back_to_back();
        test_lzb();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
